gpio_debouncer: RTL
===================

Name: gpio_debouncer

Overview:
- Per-bit synchronizer and debouncer for raw board inputs (buttons, switches).
- Sits between the board pins and the core's gpio_input bus, and on the board reset-button path.
- Each bit is synchronized into the clock domain and changes its output only after the synchronized input has held the new level for DEBOUNCE_CYCLES consecutive clocks.
- Optionally emits one-cycle edge pulses, usable as interrupt or reset-request strobes.

Parameters:
- WIDTH, 3: number of independent input bits.
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks required before the output changes (10 ms at 50 MHz). Legal range is 1 to 2^24-1.
- SYNC_STAGES, 2: synchronizer flip-flop depth. Minimum 2; values below 2 are clamped to 2.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into the synchronizer and output registers on reset.

Ports:
- clock  in  1  single clock for all logic (50 MHz on board).
- reset  in  1  asynchronous active-high reset.
- gpio_raw  in  WIDTH  unsynchronized pin levels.
- gpio_debounced  out  WIDTH  debounced, registered levels.
- rise_pulse  out  WIDTH  one-cycle pulse when the matching gpio_debounced bit goes 0->1.
- fall_pulse  out  WIDTH  one-cycle pulse when the matching gpio_debounced bit goes 1->0.
- any_change  out  1  OR of all rise_pulse and fall_pulse bits, registered together with them.

Behaviour:
- Reset (async assert, removal sampled at clock edge):
  - All sync stages and gpio_debounced load RESET_VALUE.
  - Counters load 0.
  - rise_pulse, fall_pulse and any_change are 0.
  - Reset mid-count discards progress; no pulse is produced by the reset itself.
- Synchronizer: gpio_raw[i] shifts through SYNC_STAGES flops; the last stage is sync[i]. There is no other combinational path from gpio_raw to any output.
- Per-bit counter: width CW = clog2(DEBOUNCE_CYCLES+1).
  - sync[i] == gpio_debounced[i]: counter <= 0.
  - sync[i] != gpio_debounced[i] and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync[i] != gpio_debounced[i] and counter == DEBOUNCE_CYCLES-1: gpio_debounced[i] <= sync[i], counter <= 0.
- Glitch handling: any return of sync to the stable level restarts the count; a glitch shorter than DEBOUNCE_CYCLES never reaches the output.
- Latency: a clean pin step reaches gpio_debounced exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges after the first sampling edge.
- DEBOUNCE_CYCLES=1: output follows sync with one clock of delay.
- Counter wrap: impossible by construction; the counter never exceeds DEBOUNCE_CYCLES-1.
- Bit independence: bits share no state. Simultaneous changes on several bits update in the same cycle if their inputs changed in the same cycle.
- Pulses (when enabled, see Optional Feature):
  - rise_pulse[i] and fall_pulse[i] are registered and high for exactly the one cycle following the gpio_debounced[i] update.
  - They are never both high for the same bit.
  - any_change is high in the same cycle as any pulse.

Optional Feature:
- Macro: GPIO_DEBOUNCER_EDGE_PULSE_EN.
- Defined: edge-detect registers are present; rise_pulse, fall_pulse and any_change behave as above.
- Undefined: no edge registers are instantiated; rise_pulse, fall_pulse and any_change are tied to 0. gpio_debounced timing is identical in both builds.

Decomposition:
- Shared package (rvsteel constants header) holds:
  - the clog2 helper function;
  - the default DEBOUNCE_CYCLES_10MS_50MHZ = 500000;
  - the SYNC_STAGES_MIN = 2 constant.
- Sub-module gpio_debounce_cell: one bit, containing the synchronizer, counter, stable register and optional edge register.
- The top module instantiates WIDTH cells in a generate loop and ORs the pulses into any_change.

Test Plan:
Bench configuration: WIDTH=3, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_VALUE=0, macro defined unless stated.
1. Reset behaviour: hold reset with gpio_raw=3'b111, release, then set gpio_raw=0 on the same edge -> gpio_debounced=000 throughout; no pulse at any time; any_change=0.
2. Clean step: gpio_raw[0] 0->1 before edge N and held -> gpio_debounced[0]=1 after edge N+5 (6 edges); rise_pulse[0]=1 for exactly the following cycle only; any_change matches.
3. Glitch rejection: gpio_raw[1] high for 3 clocks, then low -> gpio_debounced[1] stays 0; no pulses. Repeat with 4 clocks -> output goes to 1 after 6 edges.
4. Bounce then settle: toggle gpio_raw[2] every 2 clocks for 20 clocks, then hold 1 -> exactly one rise_pulse[2], 6 edges after the final transition.
5. Simultaneous opposite edges: from state 3'b100, drive 3'b001 on one edge -> bit0 rises and bit2 falls on the same cycle; rise_pulse=001 and fall_pulse=100 together; any_change=1 for one cycle. Rebuild without the macro -> all pulse outputs stay 0 with identical gpio_debounced timing.
6. Reset mid-count: counter at 3 for bit0 (gpio_raw[0]=1 held), assert reset asynchronously between edges -> gpio_debounced[0] stays 0 immediately; after release, a full 6 edges are still required before it rises.

Source files
------------

// File: rtl/gpio_debouncer_pkg.sv
// rtl/gpio_debouncer_pkg.sv - shared constants and helpers for the gpio debouncer
package gpio_debouncer_pkg;

  // 10 ms of stable input at the 50 MHz board clock
  localparam int DEBOUNCE_CYCLES_10MS_50MHZ = 500000;

  // Fewer than two synchronizer flops leaves metastability unresolved
  localparam int SYNC_STAGES_MIN = 2;

  // Number of bits needed to hold values 0 .. value-1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpio_debouncer_cell.sv
// rtl/gpio_debouncer_cell.sv - one-bit synchronizer + debouncer (edge pulses under GPIO_DEBOUNCER_EDGE_PULSE_EN)
module gpio_debounce_cell
  import gpio_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS_50MHZ,
  parameter int   SYNC_STAGES     = SYNC_STAGES_MIN,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic debounced
`ifdef GPIO_DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_next
`endif
);

  // Requests below the minimum depth are quietly raised to it
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int CW     = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] sync_chain;
  logic              sync_level;
  logic [CW-1:0]     count;
  logic              differs;
  logic              update;

  assign sync_level = sync_chain[STAGES-1];
  assign differs    = (sync_level != debounced);
  // The output flips on the clock where the mismatch has lasted DEBOUNCE_CYCLES samples
  assign update     = differs && (count == COUNT_LAST);

  // Shift the raw pin through the synchronizer; only the last stage is used
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_chain <= {STAGES{RESET_VALUE}};
    end else begin
      sync_chain <= {sync_chain[STAGES-2:0], raw};
    end
  end

  // Count consecutive mismatching samples; any return to the stable level restarts the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      debounced <= RESET_VALUE;
    end else if (!differs) begin
      count     <= '0;
    end else if (update) begin
      count     <= '0;
      debounced <= sync_level;
    end else begin
      count     <= count + 1'b1;
    end
  end

`ifdef GPIO_DEBOUNCER_EDGE_PULSE_EN
  assign change_next = update;

  // Pulses are registered on the same edge as the output update so they cover its first cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= update & sync_level;
      fall_pulse <= update & ~sync_level;
    end
  end
`endif

endmodule

// File: rtl/gpio_debouncer.sv
// rtl/gpio_debouncer.sv - WIDTH-bit pin debouncer top (edge pulses under GPIO_DEBOUNCER_EDGE_PULSE_EN)
module gpio_debouncer
  import gpio_debouncer_pkg::*;
#(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS_50MHZ,
  parameter int               SYNC_STAGES     = SYNC_STAGES_MIN,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_raw,
  output logic [WIDTH-1:0] gpio_debounced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

`ifdef GPIO_DEBOUNCER_EDGE_PULSE_EN
  logic [WIDTH-1:0] change_next;
`endif

  // Bits are fully independent: one cell per input
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gpio_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_cell (
      .clock       (clock),
      .reset       (reset),
      .raw         (gpio_raw[i]),
      .debounced   (gpio_debounced[i])
`ifdef GPIO_DEBOUNCER_EDGE_PULSE_EN
      ,
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .change_next (change_next[i])
`endif
    );
  end

`ifdef GPIO_DEBOUNCER_EDGE_PULSE_EN
  // any_change is registered from the same strobes as the pulses so it lines up with them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_next;
    end
  end
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign any_change = 1'b0;
`endif

endmodule
